ctrl_input_conditioner: RTL



---
 rtl/ctrl_pkg.sv | 13 +
 rtl/ctrl_input_conditioner_if.sv | 9 +
 rtl/sw_debounce_bit.sv | 34 +++
 rtl/ctrl_input_conditioner.sv | 65 ++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: pad bit positions and coin channel state shared by the input conditioner
package ctrl_pkg;
  localparam int IDX_U  = 0;
  localparam int IDX_D  = 1;
  localparam int IDX_R  = 2;
  localparam int IDX_L  = 3;
  localparam int IDX_J  = 4;
  localparam int IDX_S1 = 5;
  localparam int IDX_C1 = 6;
  localparam int IDX_S2 = 7;
  localparam int IDX_C2 = 8;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} coin_state_t;
endpackage

// File: rtl/ctrl_input_conditioner_if.sv
// ctrl_input_conditioner_if: raw pad levels in, conditioned game controls out
interface ctrl_input_conditioner_if #(parameter int N_IN = 9);
  logic [N_IN-1:0] I_PAD_n;
  logic [N_IN-1:0] O_SW;
  logic [N_IN-1:0] O_SW_RISE;
  logic            O_COIN_BUSY;
  modport master(output I_PAD_n, input O_SW, O_SW_RISE, O_COIN_BUSY);
  modport slave(input I_PAD_n, output O_SW, O_SW_RISE, O_COIN_BUSY);
endinterface

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop sync of one active-low pad, debounce counter and rise pulse
module sw_debounce_bit #(
  parameter int DEB_CYCLES = 360000
) (
  input  logic CLK_36M,
  input  logic I_RESET_SWn,
  input  logic pad_n,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, act;
  logic [CW-1:0] cnt;
  assign act = ~s2;
  // synchronise the raw level; reset value is the released pad
  always_ff @(posedge CLK_36M or negedge I_RESET_SWn)
    if (!I_RESET_SWn) {s1, s2} <= 2'b11;
    else {s1, s2} <= {pad_n, s1};
  // accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge CLK_36M or negedge I_RESET_SWn)
    if (!I_RESET_SWn) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (act == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= act;
        rise   <= act;
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/ctrl_input_conditioner.sv
// ctrl_input_conditioner: sync, debounce, coin pulse-stretch and SOCD for the cabinet pads
module ctrl_input_conditioner
  import ctrl_pkg::*;
#(
  parameter int N_IN             = 9,
  parameter int DEB_CYCLES       = 360000,
  parameter int COIN_HOLD_CYCLES = 3686400,
  parameter bit SOCD_NEUTRAL     = 1'b1
) (
  input logic CLK_36M,
  input logic I_RESET_SWn,
  ctrl_input_conditioner_if.slave bus
);
  localparam int HW = $clog2(COIN_HOLD_CYCLES + 1);
  localparam logic [N_IN-1:0] PLAIN_MASK =
    N_IN'((1 << IDX_U) | (1 << IDX_D) | (1 << IDX_J) | (1 << IDX_S1) | (1 << IDX_S2));
  logic [N_IN-1:0] stable, rise, sw_nx;
  logic [1:0] coin_on, coin_act;
  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    sw_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLK_36M(CLK_36M),
      .I_RESET_SWn(I_RESET_SWn),
      .pad_n(bus.I_PAD_n[i]),
      .stable(stable[i]),
      .rise(rise[i])
    );
  end
  for (genvar c = 0; c < 2; c++) begin : g_coin
    localparam int B = (c == 0) ? IDX_C1 : IDX_C2;
    coin_state_t state, state_nx;
    logic [HW-1:0] cnt, cnt_nx;
    // coin channel state and hold counter
    always_ff @(posedge CLK_36M or negedge I_RESET_SWn)
      if (!I_RESET_SWn) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    // one fixed-width pulse per accepted press; wait for release before re-arming
    always_comb begin
      state_nx = state == IDLE ? (rise[B] ? HOLD : IDLE)
               : state == HOLD ? (cnt == HW'(1) ? (stable[B] ? WAIT_REL : IDLE) : HOLD)
               : (stable[B] ? WAIT_REL : IDLE);
      cnt_nx = state == HOLD ? cnt - HW'(1) : HW'(COIN_HOLD_CYCLES);
    end
    assign coin_on[c]  = state == HOLD;
    assign coin_act[c] = state != IDLE;
  end
  // merge plain debounced bits, coin pulses and the L/R conflict rule
  always_comb begin
    sw_nx         = stable & PLAIN_MASK;
    sw_nx[IDX_L]  = stable[IDX_L] & ~(SOCD_NEUTRAL & stable[IDX_R]);
    sw_nx[IDX_R]  = stable[IDX_R] & ~(SOCD_NEUTRAL & stable[IDX_L]);
    sw_nx[IDX_C1] = coin_on[0];
    sw_nx[IDX_C2] = coin_on[1];
  end
  // registered game-facing control vector
  always_ff @(posedge CLK_36M or negedge I_RESET_SWn)
    if (!I_RESET_SWn) bus.O_SW <= '0;
    else bus.O_SW <= sw_nx;
  assign bus.O_SW_RISE   = rise;
  assign bus.O_COIN_BUSY = |coin_act;
endmodule
